fp_div_sched: RTL and testbench

Round-robin scheduler that shares one multi-cycle bfloat16 divider (`fp_div`) among `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake, drives the divider's `start`/`opA`/`opB`, and waits for the divider's `valid`. It then returns the quotient and exception flags to the requester that issued the operation. A watchdog bounds the wait so a hung divider cannot deadlock the requesters.

---
 rtl/fp_div_sched.sv | 147 ++++++++++++++
 tb/tb_fp_div_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sched.sv
// Round-robin scheduler sharing one multi-cycle bfloat16 divider among NREQ requesters.
// One operation is outstanding at a time; a watchdog answers with qNaN if the divider hangs.
module fp_div_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_opA,
    input  logic [NREQ*16-1:0]   req_opB,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [15:0]          rsp_quotient,
    output logic [3:0]           rsp_flags,
    output logic                 div_start,
    output logic [15:0]          div_opA,
    output logic [15:0]          div_opB,
    input  logic [15:0]          div_quotient,
    input  logic                 div_underflow,
    input  logic                 div_overflow,
    input  logic                 div_inexact,
    input  logic                 div_valid,
    output logic                 busy,
    output logic [7:0]           timeout_cnt
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [15:0] QNAN = 16'h7FC0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  owner_q;
    logic [TMR_W-1:0]  timer_q;
    logic [15:0]       opa_q;
    logic [15:0]       opb_q;
    logic [15:0]       quot_q;
    logic [3:0]        flags_q;
    logic [7:0]        tocnt_q;

    logic [PTR_W-1:0]  grant_d;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic              grant_vld_d;
    logic [15:0]       sel_opa_d;
    logic [15:0]       sel_opb_d;

    always_comb begin
        int cand_i;
        cand_i      = 0;
        grant_d     = rr_ptr_q;
        grant_vld_d = 1'b0;
        // Scan farthest-first so the nearest requester at or after rr_ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_i = (int'(rr_ptr_q) + k) % NREQ;
            if (req_valid[PTR_W'(cand_i)]) begin
                grant_d     = PTR_W'(cand_i);
                grant_vld_d = 1'b1;
            end
        end

        sel_opa_d = '0;
        sel_opb_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_d == PTR_W'(k)) begin
                sel_opa_d = req_opA[16*k +: 16];
                sel_opb_d = req_opB[16*k +: 16];
            end
        end

        rr_ptr_d = (grant_d == PTR_LAST) ? '0 : grant_d + PTR_W'(1);
    end

    // The grant is offered only while out of reset so nothing is accepted during reset.
    assign req_ready    = (state_q == IDLE && !reset && grant_vld_d) ? (ONE_HOT0 << grant_d) : '0;
    assign rsp_valid    = (state_q == RESP) ? (ONE_HOT0 << owner_q) : '0;
    assign rsp_quotient = quot_q;
    assign rsp_flags    = flags_q;
    assign div_start    = (state_q == ISSUE);
    assign div_opA      = opa_q;
    assign div_opB      = opb_q;
    assign busy         = (state_q != IDLE);
    assign timeout_cnt  = tocnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            timer_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            quot_q   <= '0;
            flags_q  <= '0;
            tocnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        opa_q    <= sel_opa_d;
                        opb_q    <= sel_opb_d;
                        owner_q  <= grant_d;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle beats the watchdog.
                    if (div_valid) begin
                        quot_q  <= div_quotient;
                        flags_q <= {1'b0, div_underflow, div_overflow, div_inexact};
                        state_q <= RESP;
                    end else if (timer_q == TMR_LAST) begin
                        quot_q  <= QNAN;
                        flags_q <= 4'b1000;
                        if (tocnt_q != 8'hFF) begin
                            tocnt_q <= tocnt_q + 8'd1;
                        end
                        state_q <= RESP;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_sched.sv
// Bench for fp_div_sched: the bench plays the divider and every requester, and
// predicts grants, latencies and responses from a round-robin/scoreboard model.
module tb_fp_div_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*16-1:0]  req_opA;
    logic [NREQ*16-1:0]  req_opB;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [15:0]         rsp_quotient;
    logic [3:0]          rsp_flags;
    logic                div_start;
    logic [15:0]         div_opA;
    logic [15:0]         div_opB;
    logic [15:0]         div_quotient;
    logic                div_underflow;
    logic                div_overflow;
    logic                div_inexact;
    logic                div_valid;
    logic                busy;
    logic [7:0]          timeout_cnt;

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] rv;
    logic [15:0]     opa [NREQ];
    logic [15:0]     opb [NREQ];
    int              mptr;
    int              exp_tocnt;

    fp_div_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_opA(req_opA), .req_opB(req_opB), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_flags(rsp_flags),
        .div_start(div_start), .div_opA(div_opA), .div_opB(div_opB),
        .div_quotient(div_quotient), .div_underflow(div_underflow),
        .div_overflow(div_overflow), .div_inexact(div_inexact), .div_valid(div_valid),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        req_valid = rv;
        for (int i = 0; i < NREQ; i++) begin
            req_opA[16*i +: 16] = opa[i];
            req_opB[16*i +: 16] = opb[i];
        end
    endtask

    // First pending requester at or after the model pointer, modulo NREQ.
    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (rv[2'((mptr + k) % NREQ)]) return (mptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_quot"}, rsp_quotient, 0);
        chk({tag, "_rsp_flags"}, rsp_flags, 0);
        chk({tag, "_div_start"}, div_start, 0);
        chk({tag, "_div_opA"}, div_opA, 0);
        chk({tag, "_div_opB"}, div_opB, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tocnt"}, timeout_cnt, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rv = '1;
        drive_reqs();
        rsp_ready = '1;
        div_valid = 1'b1;
        tick();
        tick();
        #1;
        chk_rst("rst");
        rv = '0;
        drive_reqs();
        rsp_ready = '0;
        div_valid = 1'b0;
        reset = 1'b0;
        mptr = 0;
        exp_tocnt = 0;
    endtask

    // One full transaction starting from IDLE at a falling edge.
    // lat = WAIT cycles before div_valid (>= TIMEOUT means the divider never answers).
    task automatic do_op(input int exp_g, input int lat, input logic [15:0] q,
                         input logic [2:0] fl, input int hold, input bit stale);
        int g;
        int n;
        bit to;
        logic [1:0] gi;
        logic [NREQ-1:0] oh;
        logic [15:0] ea, eb, eq;
        logic [3:0] ef;
        g  = (exp_g >= 0) ? exp_g : model_grant();
        gi = 2'(g);
        oh = NREQ'(1) << g;
        ea = opa[gi];
        eb = opb[gi];
        div_valid = stale;
        div_quotient = 16'hDEAD;
        {div_underflow, div_overflow, div_inexact} = stale ? 3'b111 : 3'b000;
        rsp_ready = '0;
        drive_reqs();
        #1;
        chk("idle_req_ready", req_ready, oh);
        chk("idle_busy", busy, 0);
        tick();
        rv = rv & ~oh;
        mptr = (g + 1) % NREQ;
        drive_reqs();
        #1;
        chk("issue_start", div_start, 1);
        chk("issue_opA", div_opA, ea);
        chk("issue_opB", div_opB, eb);
        chk("issue_req_ready", req_ready, 0);
        chk("issue_rsp_valid", rsp_valid, 0);
        tick();
        to = (lat >= TIMEOUT);
        n  = to ? TIMEOUT : lat + 1;
        for (int i = 1; i <= n; i++) begin
            if (!to && i == n) begin
                div_valid = 1'b1;
                div_quotient = q;
                {div_underflow, div_overflow, div_inexact} = fl;
            end else begin
                div_valid = 1'b0;
                div_quotient = 16'($urandom);
                {div_underflow, div_overflow, div_inexact} = 3'($urandom);
            end
            #1;
            chk("wait_rsp_valid", rsp_valid, 0);
            chk("wait_start", div_start, 0);
            chk("wait_busy", busy, 1);
            tick();
        end
        if (to) begin
            eq = 16'h7FC0;
            ef = 4'b1000;
            if (exp_tocnt < 255) exp_tocnt++;
        end else begin
            eq = q;
            ef = {1'b0, fl};
        end
        for (int h = 0; h <= hold; h++) begin
            div_valid = stale;
            div_quotient = 16'hBEEF;
            {div_underflow, div_overflow, div_inexact} = stale ? 3'b111 : 3'b000;
            rsp_ready = (h == hold) ? (4'($urandom) | oh) : (4'($urandom) & ~oh);
            req_valid = rv | 4'($urandom);
            #1;
            chk("resp_valid", rsp_valid, oh);
            chk("resp_quot", rsp_quotient, eq);
            chk("resp_flags", rsp_flags, ef);
            chk("resp_req_ready", req_ready, 0);
            chk("resp_busy", busy, 1);
            chk("resp_opA", div_opA, ea);
            chk("resp_opB", div_opB, eb);
            tick();
        end
        rsp_ready = '0;
        drive_reqs();
        #1;
        chk("after_busy", busy, 0);
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_tocnt", timeout_cnt, exp_tocnt);
    endtask

    task automatic rand_ops_for(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
        end
        rv = mask;
    endtask

    initial begin
        reset = 1'b1;
        rv = '0;
        rsp_ready = '0;
        div_valid = 1'b0;
        div_quotient = '0;
        {div_underflow, div_overflow, div_inexact} = 3'b000;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        drive_reqs();
        mptr = 0;
        exp_tocnt = 0;

        do_reset();

        // Single op: 20 / 4 = 5
        rv = 4'b0001; opa[0] = 16'h41A0; opb[0] = 16'h4080;
        do_op(0, 2, 16'h40A0, 3'b000, 0, 1'b0);

        // Sign cases: -20/4 = -5 exact; 32/-1.0625 = -30.12 rounds to C1F1, inexact
        rv = 4'b0010; opa[1] = 16'hC1A0; opb[1] = 16'h4080;
        do_op(1, 0, 16'hC0A0, 3'b000, 0, 1'b0);
        rv = 4'b0100; opa[2] = 16'h4200; opb[2] = 16'hBF88;
        do_op(2, 4, 16'hC1F1, 3'b001, 1, 1'b0);

        // Round-robin from reset, then req1+req3 with pointer back at 0
        do_reset();
        rand_ops_for(4'b1111);
        do_op(0, 1, 16'h1111, 3'b100, 0, 1'b0);
        do_op(1, 3, 16'h2222, 3'b010, 0, 1'b0);
        do_op(2, 0, 16'h3333, 3'b001, 0, 1'b0);
        do_op(3, 5, 16'h4444, 3'b111, 0, 1'b0);
        rand_ops_for(4'b1010);
        do_op(1, 2, 16'h5555, 3'b000, 0, 1'b0);
        do_op(3, 2, 16'h6666, 3'b011, 0, 1'b0);

        // Backpressure on requester 2
        rand_ops_for(4'b0100);
        do_op(2, 1, 16'h3F80, 3'b101, 5, 1'b0);

        // Hung divider, stale valid, and the last-cycle race in both directions
        rand_ops_for(4'b0001);
        do_op(0, 100, 16'h0000, 3'b000, 0, 1'b0);
        rand_ops_for(4'b0010);
        do_op(1, 2, 16'h4049, 3'b001, 2, 1'b1);
        rand_ops_for(4'b1000);
        do_op(3, TIMEOUT - 1, 16'h7F7F, 3'b010, 0, 1'b0);
        rand_ops_for(4'b0001);
        do_op(0, TIMEOUT, 16'h1234, 3'b000, 0, 1'b0);

        // Reset in WAIT, 4 cycles after the start pulse
        rand_ops_for(4'b0100);
        drive_reqs();
        div_valid = 1'b0;
        #1;
        chk("rw_req_ready", req_ready, 4'b0100);
        tick();
        rv = '0;
        drive_reqs();
        #1;
        chk("rw_start", div_start, 1);
        for (int i = 0; i < 4; i++) tick();
        rv = 4'b1001;
        drive_reqs();
        reset = 1'b1;
        #1;
        chk_rst("rw_async");
        tick();
        #1;
        chk_rst("rw_hold");
        reset = 1'b0;
        mptr = 0;
        exp_tocnt = 0;
        do_op(0, 1, 16'hABCD, 3'b000, 0, 1'b0);
        do_op(3, 1, 16'hDCBA, 3'b001, 0, 1'b0);

        // Randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = 16'($urandom);
                opb[i] = 16'($urandom);
            end
            rv = rv | 4'($urandom);
            if (rv == '0) rv = 4'(1) << $urandom_range(0, NREQ - 1);
            do_op(-1,
                  ($urandom_range(0, 9) == 0) ? TIMEOUT + 8 : int'($urandom_range(0, 8)),
                  16'($urandom), 3'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
